// File: rtl/vga_pkg.sv
// Shared raster constants for the 800x600@60 display path; drawing stages
// import this so their blanking limits match the timing generator.
package vga_pkg;

  localparam int COUNT_W = 11;

  localparam int D_H_ACTIVE = 800;
  localparam int D_H_FP     = 40;
  localparam int D_H_SYNC   = 128;
  localparam int D_H_BP     = 88;
  localparam int D_H_TOTAL  = D_H_ACTIVE + D_H_FP + D_H_SYNC + D_H_BP;

  localparam int D_V_ACTIVE = 600;
  localparam int D_V_FP     = 1;
  localparam int D_V_SYNC   = 4;
  localparam int D_V_BP     = 23;
  localparam int D_V_TOTAL  = D_V_ACTIVE + D_V_FP + D_V_SYNC + D_V_BP;

  // Inclusive window test on a raster coordinate.
  function automatic logic in_window(input logic [COUNT_W-1:0] val,
                                     input logic [COUNT_W-1:0] lo,
                                     input logic [COUNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with carry-in/carry-out whose blank and sync
// flags are decoded from the next count so they land with the count itself.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 800,
  parameter int FP     = 40,
  parameter int SYNC   = 128,
  parameter int BP     = 88
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               i_cin,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_cout,
  output logic               o_blnk,
  output logic               o_sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [COUNT_W-1:0] C_LAST     = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] C_BLNK_LO  = COUNT_W'(ACTIVE);
  localparam logic [COUNT_W-1:0] C_SYNC_LO  = COUNT_W'(ACTIVE + FP);
  localparam logic [COUNT_W-1:0] C_SYNC_HI  = COUNT_W'(ACTIVE + FP + SYNC - 1);

  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_next;
  logic               r_blnk;
  logic               r_sync;
  logic               w_at_last;

  assign w_at_last = (r_count == C_LAST);
  assign o_cout    = i_cin & w_at_last;

  always_comb begin
    w_next = r_count;
    if (i_cin) begin
      w_next = w_at_last ? '0 : r_count + 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_blnk  <= 1'b0;
      r_sync  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_blnk  <= in_window(w_next, C_BLNK_LO, C_LAST);
      r_sync  <= in_window(w_next, C_SYNC_LO, C_SYNC_HI);
    end
  end

  assign o_count = r_count;
  assign o_blnk  = r_blnk;
  assign o_sync  = r_sync;

endmodule

// File: rtl/vga_timing.sv
// Free-running raster timing generator; all outputs registered and aligned.
// Optional frame_start pulse is built when VGA_TIMING_FRAME_PULSE_EN is defined.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = D_H_ACTIVE,
  parameter int H_FP     = D_H_FP,
  parameter int H_SYNC   = D_H_SYNC,
  parameter int H_BP     = D_H_BP,
  parameter int V_ACTIVE = D_V_ACTIVE,
  parameter int V_FP     = D_V_FP,
  parameter int V_SYNC   = D_V_SYNC,
  parameter int V_BP     = D_V_BP
) (
  input  logic               pclk,
  input  logic               rst,
  output logic [COUNT_W-1:0] hcount,
  output logic               hsync,
  output logic               hblnk,
  output logic [COUNT_W-1:0] vcount,
  output logic               vsync,
  output logic               vblnk
`ifdef VGA_TIMING_FRAME_PULSE_EN
  ,
  output logic               frame_start
`endif
);

  logic w_h_cout;
  logic w_v_cout;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h (
    .pclk    (pclk),
    .rst     (rst),
    .i_cin   (1'b1),
    .o_count (hcount),
    .o_cout  (w_h_cout),
    .o_blnk  (hblnk),
    .o_sync  (hsync)
  );

  // Vertical axis advances only on the edge where the line wraps.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v (
    .pclk    (pclk),
    .rst     (rst),
    .i_cin   (w_h_cout),
    .o_count (vcount),
    .o_cout  (w_v_cout),
    .o_blnk  (vblnk),
    .o_sync  (vsync)
  );

`ifdef VGA_TIMING_FRAME_PULSE_EN
  logic r_frame_start;

  // Vertical carry-out marks the edge that lands on (0,0), so the pulse is
  // registered alongside the counters and never fires in the reset state.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_v_cout;
    end
  end

  assign frame_start = r_frame_start;
`else
  logic w_unused;
  assign w_unused = w_v_cout;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a shrunk-raster instance checked over two frames plus
// a default-geometry instance checked across its first line wrap.
module tb_vga_timing;

  localparam int SHA = 16, SHF = 4, SHS = 8, SHB = 4;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVA = 12, SVF = 1, SVS = 2, SVB = 3;
  localparam int SVT = SVA + SVF + SVS + SVB;

  localparam int DHA = 800, DHF = 40, DHS = 128, DHT = 1056;
  localparam int DVA = 600, DVF = 1, DVS = 4, DVT = 628;

  typedef struct packed {
    logic [10:0] h;
    logic        hs;
    logic        hb;
    logic [10:0] v;
    logic        vs;
    logic        vb;
    logic        fs;
  } obs_t;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  logic [10:0] s_hcount, s_vcount, d_hcount, d_vcount;
  logic        s_hsync, s_hblnk, s_vsync, s_vblnk;
  logic        d_hsync, d_hblnk, d_vsync, d_vblnk;
`ifdef VGA_TIMING_FRAME_PULSE_EN
  logic        s_fs, d_fs;
`endif

  always #5 pclk = ~pclk;

  vga_timing #(
    .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
    .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB)
  ) u_dut (
    .pclk        (pclk),
    .rst         (rst),
    .hcount      (s_hcount),
    .hsync       (s_hsync),
    .hblnk       (s_hblnk),
    .vcount      (s_vcount),
    .vsync       (s_vsync),
    .vblnk       (s_vblnk)
`ifdef VGA_TIMING_FRAME_PULSE_EN
    ,
    .frame_start (s_fs)
`endif
  );

  vga_timing u_def (
    .pclk        (pclk),
    .rst         (rst),
    .hcount      (d_hcount),
    .hsync       (d_hsync),
    .hblnk       (d_hblnk),
    .vcount      (d_vcount),
    .vsync       (d_vsync),
    .vblnk       (d_vblnk)
`ifdef VGA_TIMING_FRAME_PULSE_EN
    ,
    .frame_start (d_fs)
`endif
  );

  obs_t q_s[$];
  obs_t q_d[$];
  int   sh, sv, dh, dv;
  bit   s_run, d_run;
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t model(int h, int v, int ha, int hf, int hs,
                                 int va, int vf, int vs, bit run);
    obs_t e;
    e.h  = 11'(h);
    e.hb = (h >= ha);
    e.hs = (h >= ha + hf) && (h < ha + hf + hs);
    e.v  = 11'(v);
    e.vb = (v >= va);
    e.vs = (v >= va + vf) && (v < va + vf + vs);
`ifdef VGA_TIMING_FRAME_PULSE_EN
    e.fs = run && (h == 0) && (v == 0);
`else
    e.fs = 1'b0;
`endif
    return e;
  endfunction

  function automatic obs_t act_s();
    obs_t a;
    a.h = s_hcount; a.hs = s_hsync; a.hb = s_hblnk;
    a.v = s_vcount; a.vs = s_vsync; a.vb = s_vblnk;
`ifdef VGA_TIMING_FRAME_PULSE_EN
    a.fs = s_fs;
`else
    a.fs = 1'b0;
`endif
    return a;
  endfunction

  function automatic obs_t act_d();
    obs_t a;
    a.h = d_hcount; a.hs = d_hsync; a.hb = d_hblnk;
    a.v = d_vcount; a.vs = d_vsync; a.vb = d_vblnk;
`ifdef VGA_TIMING_FRAME_PULSE_EN
    a.fs = d_fs;
`else
    a.fs = 1'b0;
`endif
    return a;
  endfunction

  task automatic reset_models();
    sh = 0; sv = 0; dh = 0; dv = 0;
    s_run = 1'b0; d_run = 1'b0;
  endtask

  task automatic advance();
    if (!rst) begin
      s_run = 1'b1;
      d_run = 1'b1;
      if (sh == SHT - 1) begin
        sh = 0;
        sv = (sv == SVT - 1) ? 0 : sv + 1;
      end else begin
        sh++;
      end
      if (dh == DHT - 1) begin
        dh = 0;
        dv = (dv == DVT - 1) ? 0 : dv + 1;
      end else begin
        dh++;
      end
    end
  endtask

  task automatic push_exp();
    q_s.push_back(model(sh, sv, SHA, SHF, SHS, SVA, SVF, SVS, s_run));
    q_d.push_back(model(dh, dv, DHA, DHF, DHS, DVA, DVF, DVS, d_run));
  endtask

  task automatic check_out(input string tag);
    obs_t e, a;
    e = q_s.pop_front();
    a = act_s();
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s small: observed h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b expected h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b",
             tag, a.h, a.v, a.hs, a.hb, a.vs, a.vb, a.fs, e.h, e.v, e.hs, e.hb, e.vs, e.vb, e.fs);
    end
    e = q_d.pop_front();
    a = act_d();
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s default: observed h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b expected h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b",
             tag, a.h, a.v, a.hs, a.hb, a.vs, a.vb, a.fs, e.h, e.v, e.hs, e.hb, e.vs, e.vb, e.fs);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge pclk);
    advance();
    push_exp();
    @(negedge pclk);
    check_out(tag);
  endtask

  initial begin
    bit found;
    reset_models();
    rst = 1'b1;
    @(negedge pclk);
    repeat (10) cycle("reset_hold");

    rst = 1'b0;
    cycle("first_edge");

    // Two small frames plus margin; the default instance crosses its line wrap.
    repeat (2 * SHT * SVT + 5) cycle("raster");

    found = 1'b0;
    for (int i = 0; i < 2 * SHT * SVT; i++) begin
      if (sh == 20 && sv == 9) begin
        found = 1'b1;
        break;
      end
      cycle("seek");
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL seek_timeout: observed h=%0d v=%0d expected h=20 v=9", sh, sv);
    end

    #2 rst = 1'b1;
    #1;
    reset_models();
    push_exp();
    check_out("async_reset");
    repeat (3) cycle("reset_mid");

    rst = 1'b0;
    cycle("resume");
    repeat (SHT * SVT + 3) cycle("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Free-running raster timing generator for the 800x600 @ 60 Hz display path (40 MHz pclk). Produces the horizontal/vertical counters, sync and blanking signals consumed by the first drawing stage: background fill, then rectangle overlay, then output pins. All outputs are registered and mutually aligned, so downstream stages see one coherent pixel coordinate per cycle.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width
- H_BP, 88, horizontal back porch
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width
- V_BP, 23, vertical back porch

Ports:
- pclk  input  1  pixel clock, 40 MHz
- rst  input  1  asynchronous, active-high reset
- hcount  output  11  current pixel column, 0..H_TOTAL-1
- hsync  output  1  horizontal sync, active-high
- hblnk  output  1  horizontal blanking
- vcount  output  11  current line, 0..V_TOTAL-1
- vsync  output  1  vertical sync, active-high
- vblnk  output  1  vertical blanking
- frame_start  output  1  one-cycle frame pulse (only with VGA_TIMING_FRAME_PULSE_EN)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628). Both must be ≤ 2048; the 11-bit width is fixed.
- hcount increments every pclk. At H_TOTAL-1, it wraps to 0 on the next edge.
- vcount increments only on the edge where hcount wraps. At vcount=V_TOTAL-1 and hcount=H_TOTAL-1, both counters wrap to 0 on the same edge.
- hblnk = 1 for hcount in [H_ACTIVE, H_TOTAL-1], i.e. [800,1055].
- hsync = 1 for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [840,967].
- vblnk = 1 for vcount in [V_ACTIVE, V_TOTAL-1], i.e. [600,627]; it is held for whole lines.
- vsync = 1 for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [601,604].
- There is no enable input and no stall. The generator never stops once reset is released.

## Timing
- Reset (asynchronous): hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, frame_start=0. These values are consistent with coordinate (0,0).
- First edge after rst deasserts: hcount=1, vcount=0.
- Flags are decoded from the next-count values and registered. In any cycle, hsync/hblnk/vsync/vblnk describe exactly the hcount/vcount presented in that same cycle, with zero relative skew.
- Line period: 1056 cycles. Frame period: 1056*628 = 663168 cycles.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). Counting restarts from (0,0) with no partial-line artefact.

## Configuration
- Macro: VGA_TIMING_FRAME_PULSE_EN.
- Defined: frame_start is a port. It is 1 for exactly the one cycle in which hcount=0 and vcount=0, excluding the reset state itself. The first pulse occurs 663168 cycles after reset release.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package vga_pkg holds:
  - default timing constants (H_/V_ ACTIVE, FP, SYNC, BP)
  - derived H_TOTAL/V_TOTAL
  - COUNT_W = 11
- Drawing stages import the same package so that the blanking limits match.
- One sub-module: vga_axis_counter. It is a parameterised wrap counter with a carry-in and a carry-out. It decodes the blank and sync windows from its next value.
- vga_timing instantiates it twice: horizontal with carry-in tied 1; vertical with carry-in from the horizontal carry-out.

## Test plan
- Reset held 10 cycles, then released: all outputs are 0 during reset. After the first edge: hcount=1, vcount=0, all flags 0.
- Run one line: hblnk rises at hcount=800. hsync is high for exactly 128 cycles from hcount=840. hcount goes 1055 -> 0 and vcount goes 0 -> 1 on the same edge.
- Run one full frame: vblnk rises at vcount=600. vsync is high for lines 601..604 (4*1056 cycles). The wrap (627,1055) -> (0,0) occurs at cycle 663168.
- Flag alignment check over two frames: each flag equals the window function of the same-cycle hcount/vcount. Zero mismatches allowed.
- Assert rst at (300,400) for 3 cycles: outputs go to 0 asynchronously. After release, counting resumes at (1,0).
- Build with VGA_TIMING_FRAME_PULSE_EN: exactly one frame_start pulse per 663168 cycles, coincident with (0,0). No pulse in the reset state.
